// File: rtl/skullfet_wb_tester.sv
// skullfet_wb_tester
//   Wishbone-slave test harness for a SkullFET inverter. The management SoC
//   programs HALF/COUNT/CTRL, then START launches either a toggle run (every
//   half-period the stimulus inverts and the synchronised response is checked
//   for correct inversion on the half-period's last cycle) or an edge run
//   (rising edges of the synchronised response are counted over a window).
//
// Ports
//   wb_clk_i, rst_n          clock, async active-low reset
//   wbs_stb_i/cyc_i/we_i     Wishbone classic request
//   wbs_sel_i, wbs_adr_i     byte enables, byte address
//   wbs_dat_i / wbs_dat_o    write / read data (read valid with ack)
//   wbs_ack_o                single-cycle acknowledge
//   stim_o, stim_oeb_o       stimulus pin and its pad output-enable (tied 0)
//   resp_i                   inverter output, asynchronous
//   irq_o                    level interrupt = done & IRQ_EN
//
// Register map (offset = wbs_adr_i[4:2]):
//   0 CTRL   [0] START (W1, self-clearing) [1] MODE [2] ABORT (W1) [3] STIM_IDLE [4] IRQ_EN
//   1 STATUS [0] busy [1] done [2] fail          (RO)
//   2 HALF   [15:0] half-period in cycles, min 4  (RW, reset 4)
//   3 COUNT  [31:0]                              (RW)
//   4 RESULT [31:0] saturating                   (RO)
//   5-7      read 0, writes ignored
module skullfet_wb_tester #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        stim_o,
  output logic        stim_oeb_o,
  input  logic        resp_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOGGLE,
    S_CHECK,
    S_EDGE,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------------
  logic        req;
  logic        acc;
  logic        wr;
  logic [2:0]  ofs;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rd_data;
  logic        unused_adr;

  assign req        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A request is accepted only when ack is low, so ack can never be high on
  // two consecutive cycles.
  assign acc        = req & ~ack_q;
  assign wr         = acc & wbs_we_i;
  assign ofs        = wbs_adr_i[4:2];
  assign unused_adr = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Programmable registers
  // ---------------------------------------------------------------------------
  logic        mode_q;
  logic        stim_idle_q;
  logic        irq_en_q;
  logic [15:0] half_q;
  logic [31:0] count_q;
  logic        start_q;
  logic        abort_q;

  // ---------------------------------------------------------------------------
  // Run state
  // ---------------------------------------------------------------------------
  state_t      state_q, state_n;
  logic [15:0] tmr_q, tmr_n;
  logic [31:0] rem_q, rem_n;
  logic [31:0] res_q, res_n;
  logic [31:0] res_inc;
  logic        stim_q, stim_n;
  logic        done_q, done_n;
  logic        fail_q, fail_n;
  logic [15:0] half_w_q, half_w_n;
  logic        mode_w_q, mode_w_n;
  logic [15:0] half_eff;
  logic        busy;
  logic        launch;

  logic        sync1_q;
  logic        resp_s;
  logic        resp_d;

  assign busy       = (state_q == S_TOGGLE) | (state_q == S_CHECK) | (state_q == S_EDGE);
  assign half_eff   = (half_q < 16'd4) ? 16'd4 : half_q;
  assign res_inc    = (res_q == '1) ? res_q : res_q + 32'd1;
  assign launch     = start_q & ((state_q == S_IDLE) | (state_q == S_DONE));

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign stim_o     = stim_q;
  assign stim_oeb_o = 1'b0;
  assign irq_o      = done_q & irq_en_q;

  // ---------------------------------------------------------------------------
  // Bus handshake and register writes
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    case (ofs)
      3'd0:    rd_data = {27'd0, irq_en_q, stim_idle_q, 1'b0, mode_q, 1'b0};
      3'd1:    rd_data = {29'd0, fail_q, done_q, busy};
      3'd2:    rd_data = {16'd0, half_q};
      3'd3:    rd_data = count_q;
      3'd4:    rd_data = res_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      mode_q      <= 1'b0;
      stim_idle_q <= 1'b0;
      irq_en_q    <= 1'b0;
      half_q      <= 16'd4;
      count_q     <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      ack_q   <= acc;
      dat_q   <= (acc & ~wbs_we_i) ? rd_data : '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      if (wr) begin
        case (ofs)
          3'd0: begin
            if (wbs_sel_i[0]) begin
              start_q     <= wbs_dat_i[0];
              mode_q      <= wbs_dat_i[1];
              abort_q     <= wbs_dat_i[2];
              stim_idle_q <= wbs_dat_i[3];
              irq_en_q    <= wbs_dat_i[4];
            end
          end
          3'd2: begin
            if (wbs_sel_i[0]) half_q[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) half_q[15:8] <= wbs_dat_i[15:8];
          end
          3'd3: begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (wbs_sel_i[b]) count_q[8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response synchroniser and edge history
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      resp_s  <= 1'b0;
      resp_d  <= 1'b0;
    end else begin
      sync1_q <= resp_i;
      resp_s  <= sync1_q;
      resp_d  <= resp_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Run controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      stim_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      half_w_q <= 16'd4;
      mode_w_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      tmr_q    <= tmr_n;
      rem_q    <= rem_n;
      res_q    <= res_n;
      stim_q   <= stim_n;
      done_q   <= done_n;
      fail_q   <= fail_n;
      half_w_q <= half_w_n;
      mode_w_q <= mode_w_n;
    end
  end

  // The timer is loaded with HALF-2 so TOGGLE lasts HALF-1 cycles and CHECK
  // supplies the half-period's final cycle. The DONE actions (done, fail)
  // land on the edge that leaves DONE, so irq_o rises the cycle after DONE.
  always_comb begin
    state_n  = state_q;
    tmr_n    = tmr_q;
    rem_n    = rem_q;
    res_n    = res_q;
    stim_n   = stim_q;
    done_n   = done_q;
    fail_n   = fail_q;
    half_w_n = half_w_q;
    mode_w_n = mode_w_q;

    if (abort_q) begin
      state_n = S_IDLE;
      done_n  = 1'b0;
      fail_n  = 1'b0;
      stim_n  = stim_idle_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          stim_n = stim_idle_q;
        end
        S_TOGGLE: begin
          if (tmr_q == '0) state_n = S_CHECK;
          else             tmr_n   = tmr_q - 16'd1;
        end
        S_CHECK: begin
          if (resp_s != ~stim_q) res_n = res_inc;
          rem_n = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            state_n = S_DONE;
            stim_n  = stim_idle_q;
          end else begin
            state_n = S_TOGGLE;
            stim_n  = ~stim_q;
            tmr_n   = half_w_q - 16'd2;
          end
        end
        S_EDGE: begin
          stim_n = stim_idle_q;
          if (resp_s & ~resp_d) res_n = res_inc;
          rem_n = rem_q - 32'd1;
          if (rem_q == 32'd1) state_n = S_DONE;
        end
        S_DONE: begin
          stim_n  = stim_idle_q;
          done_n  = 1'b1;
          fail_n  = ~mode_w_q & (res_q != '0);
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
          stim_n  = stim_idle_q;
        end
      endcase

      if (launch) begin
        done_n   = 1'b0;
        fail_n   = 1'b0;
        res_n    = '0;
        half_w_n = half_eff;
        mode_w_n = mode_q;
        rem_n    = count_q;
        tmr_n    = half_eff - 16'd2;
        if (count_q == '0) begin
          state_n = S_DONE;
          stim_n  = stim_idle_q;
        end else if (!mode_q) begin
          state_n = S_TOGGLE;
          stim_n  = ~stim_idle_q;
        end else begin
          state_n = S_EDGE;
          stim_n  = stim_idle_q;
        end
      end
    end
  end

endmodule

// File: doc/skullfet_wb_tester.md
# skullfet_wb_tester

Wishbone-slave test harness for SkullFET cells in the user project area. The management SoC programs a run over Wishbone; the block drives a stimulus pin into a SkullFET inverter input and samples the inverter output back through a synchronizer. It either checks every toggle for correct inversion (toggle mode) or counts output rising edges over a window (edge mode, for ring oscillators or external sources). It sits in `user_project_wrapper` between the Wishbone slave port and the cell's `io_in`/`io_out` pins.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: decoded on `wbs_adr_i[31:8]`.
- `wb_clk_i`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, asynchronous, active-low; the wrapper drives it as `~wb_rst_i`.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe, cycle and write enable.
- `wbs_sel_i`  in  4  byte enables for writes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid while `wbs_ack_o` is high.
- `stim_o`  out  1  drives the SkullFET inverter input A.
- `stim_oeb_o`  out  1  pad output-enable, active-low; constant 0.
- `resp_i`  in  1  inverter output Y, asynchronous to the clock.
- `irq_o`  out  1  level interrupt, equal to `done & IRQ_EN`.

## Operation
Register map. Offset is `wbs_adr_i[4:2]`.
- 0x00 CTRL (RW):
  - [0] START: write 1 to start; self-clearing; reads 0.
  - [1] MODE: 0 = toggle, 1 = edge.
  - [2] ABORT: write 1 to abort; self-clearing.
  - [3] STIM_IDLE: level driven on `stim_o` while not running.
  - [4] IRQ_EN.
- 0x04 STATUS (RO):
  - [0] busy.
  - [1] done: sticky; cleared by START or ABORT.
  - [2] fail: set when done, MODE=0 and RESULT != 0.
- 0x08 HALF (RW) [15:0]: half-period in cycles. Reset value 4. Any value below 4 is used as 4.
- 0x0C COUNT (RW) [31:0]: number of half-periods (toggle mode) or window length in cycles (edge mode).
- 0x10 RESULT (RO) [31:0]: mismatch count (toggle mode) or rising-edge count (edge mode). Saturates at 32'hFFFF_FFFF.
- Offsets 0x14–0x1C: reads return 0; writes are ignored; still acked.

Wishbone behaviour:
- A cycle is addressed when `stb & cyc` and `adr[31:8] == BASE_ADDR[31:8]`.
- `wbs_ack_o` rises the cycle after the request, stays high for one cycle, and is forced low the following cycle. No back-to-back acks.
- Requests outside the decoded range are never acked.
- Writes honour `wbs_sel_i` per byte.

`resp_i` path: two-flop synchronizer feeding a sampled value `resp_s`. `resp_s` lags the pin by 2 cycles.

FSM states: IDLE, TOGGLE, CHECK, EDGE, DONE.
- **IDLE → start.** On START with busy=0, the block latches HALF/COUNT into working copies, clears RESULT and done, and sets busy.
  - COUNT=0 → DONE.
  - MODE=0 → TOGGLE.
  - MODE=1 → EDGE.
- **TOGGLE.** `stim_o` inverts on the first cycle of each half-period, then the half-period timer runs. On the last cycle of the half-period the FSM goes to CHECK.
- **CHECK** (counts as the half-period's final cycle).
  - If `resp_s != ~stim_o`, RESULT increments.
  - Decrement the remaining count; 0 → DONE, else → TOGGLE.
- **EDGE.** `stim_o` holds STIM_IDLE.
  - Each cycle where `resp_s` is 1 and was 0 the previous cycle increments RESULT.
  - The window counter decrements every cycle; 0 → DONE.
- **DONE** (one cycle): busy=0, done=1, fail updated, `stim_o` returns to STIM_IDLE; → IDLE.
- **ABORT** (any state): → IDLE next cycle; busy=0, done=0; RESULT keeps its partial value; `stim_o` = STIM_IDLE.
- **Simultaneous events.** START while busy is ignored. START and ABORT in the same write: ABORT wins.
- **Register writes while busy.** Writes to HALF/COUNT/MODE while busy update the registers but do not affect the running test, which uses the latched copies.

## Timing
- **Reset values:** `wbs_ack_o`=0, `wbs_dat_o`=0, `stim_o`=0, `stim_oeb_o`=0, `irq_o`=0. All registers 0 except HALF=4. FSM in IDLE.
- **START latency:** START write acked at cycle T; busy reads 1 from T+1. In toggle mode the first `stim_o` edge is at T+1.
- **Toggle mode:** a run lasts COUNT×HALF cycles plus 1 for DONE. The check point is HALF−1 cycles after each edge, which leaves at least 1 cycle of settling beyond the synchronizer latency.
- **Edge mode:** a run lasts COUNT cycles plus 1.
- **Input limit:** edges on `resp_i` faster than wb_clk_i/2 are undercounted. This is documented, not checked.
- **Interrupt:** `irq_o` rises the cycle after DONE if IRQ_EN=1, and stays high until done is cleared.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → all outputs 0, HALF reads 4, STATUS reads 0; no ack is issued for a request pending at reset.
- **Toggle pass:** `resp_i` = ~`stim_o` delayed 1 cycle, HALF=8, COUNT=10, MODE=0, START → 80 cycles later STATUS=0b010, RESULT=0, `stim_o` shows 10 edges.
- **Toggle fail:** `resp_i` stuck at 0, HALF=4, COUNT=6 → RESULT=3, fail=1; with IRQ_EN=1, `irq_o` goes high.
- **Edge count:** `resp_i` square wave with period 10 cycles, MODE=1, COUNT=100 → RESULT=10 (±1); `stim_o` stays at STIM_IDLE throughout.
- **Abort/ignored start:** ABORT at cycle 20 of a 100-cycle run → busy=0, done=0, RESULT is partial; a second START while busy does not restart the run.
- **Bus rules:** write to 0x14 → acked, reads 0; address outside BASE_ADDR → no ack within 10 cycles; byte write with `wbs_sel_i`=4'b0010 to COUNT → only bits [15:8] change.
